// File: rtl/riscv_pkg.sv
// riscv: shared RV32 fetch types, reset vector and fetch queue entry layout
package riscv;
    localparam int PC_W = 9;
    typedef logic [31:0] ir_t;
    typedef logic [PC_W-1:0] pc_t;
    localparam ir_t NOP = 32'h0000_0013;
    localparam logic [31:0] INIT_PC = 32'h0000_0000;
    typedef struct packed {
        ir_t ir;
        pc_t pc;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: synchronous FIFO of fetched instructions with flush and occupancy count
module fetch_queue
    import riscv::*;
#(
    parameter int DEPTH = 2,
    parameter int CW = $clog2(DEPTH) + 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush_i,
    input  logic         push_i,
    input  fetch_entry_t entry_i,
    input  logic         pop_i,
    output fetch_entry_t head_o,
    output logic [CW-1:0] count_o,
    output logic         empty_o
);
    localparam int AW = $clog2(DEPTH);

    fetch_entry_t mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [CW-1:0] count_q;

    // entry storage needs no reset; stale slots are never read while empty
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_q] <= entry_i;
    end

    // pointers wrap naturally at DEPTH; count tracks occupancy through push/pop overlap
    always_ff @(posedge clk) begin
        if (reset || flush_i) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (push_i) wr_q <= wr_q + 1'b1;
            if (pop_i) rd_q <= rd_q + 1'b1;
            count_q <= count_q + CW'(push_i) - CW'(pop_i);
        end
    end

    assign head_o  = mem_q[rd_q];
    assign count_o = count_q;
    assign empty_o = (count_q == '0);
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC sequencing, single-cycle imem reads and a decoupling instruction queue
module fetch_stage
    import riscv::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_en,
    output pc_t         imem_addr,
    input  logic [31:0] imem_data,
    input  logic        redirect,
    input  pc_t         redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output ir_t         if_ir,
    output pc_t         if_pc
);
    localparam int CW = $clog2(DEPTH) + 1;

    pc_t pc_q, pc_d, issued_q;
    logic inflight_q, kill_q;
    logic pop, push, empty;
    logic [CW-1:0] count, credit;
    fetch_entry_t head, entry;

    // credit counts the slot freed by this cycle's pop so a full-rate stream never stalls
    assign pop       = if_valid && if_ready;
    assign credit    = count + CW'(inflight_q) - CW'(pop);
    assign imem_en   = !reset && !redirect && (credit < CW'(DEPTH));
    assign imem_addr = pc_q;
    assign push      = inflight_q && !kill_q && !redirect;
    assign entry     = '{ir: imem_data, pc: issued_q};

    // next fetch address: redirect target word-aligned, else advance on each issued read
    always_comb begin
        pc_d = redirect ? (redirect_pc & ~pc_t'(3)) : imem_en ? pc_q + pc_t'(4) : pc_q;
    end

    // PC, in-flight tracking and the kill flag that cancels a response from before a redirect
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q       <= pc_t'(INIT_PC);
            issued_q   <= '0;
            inflight_q <= 1'b0;
            kill_q     <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            inflight_q <= imem_en;
            kill_q     <= redirect;
            if (imem_en) issued_q <= pc_q;
        end
    end

    fetch_queue #(.DEPTH(DEPTH), .CW(CW)) u_queue (
        .clk    (clk),
        .reset  (reset),
        .flush_i(redirect),
        .push_i (push),
        .entry_i(entry),
        .pop_i  (pop),
        .head_o (head),
        .count_o(count),
        .empty_o(empty)
    );

    assign if_valid = !empty;
    assign if_ir    = empty ? NOP : head.ir;
    assign if_pc    = empty ? '0 : head.pc;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: scenario tasks plus a stream-level scoreboard of issued and delivered PCs
module tb_fetch_stage;
    import riscv::*;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_en;
    pc_t         imem_addr;
    logic [31:0] imem_data = '0;
    logic        redirect = 1'b0;
    pc_t         redirect_pc = '0;
    logic        if_valid;
    logic        if_ready = 1'b0;
    ir_t         if_ir;
    pc_t         if_pc;

    int total = 0;
    int bad = 0;
    int d_count = 0;
    bit mon_on = 1'b0;

    pc_t  exp_issue, exp_deliv, hold_pc;
    ir_t  hold_ir;
    int   outstanding = 0;
    logic hold_q = 1'b0;

    always #5 clk = ~clk;

    fetch_stage #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .imem_en    (imem_en),
        .imem_addr  (imem_addr),
        .imem_data  (imem_data),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .if_valid   (if_valid),
        .if_ready   (if_ready),
        .if_ir      (if_ir),
        .if_pc      (if_pc)
    );

    // memory returns the word equal to its address one cycle after the strobe, garbage otherwise
    always @(posedge clk) imem_data <= imem_en ? 32'(imem_addr) : $urandom;

    // scoreboard: delivered PCs form the issued stream in order, restarting at each redirect
    always @(negedge clk) begin
        if (mon_on) begin
            if (reset) begin
                exp_issue = pc_t'(INIT_PC);
                exp_deliv = pc_t'(INIT_PC);
                outstanding = 0;
                hold_q = 1'b0;
            end else begin
                if (hold_q) begin
                    total++;
                    if (!if_valid || if_pc !== hold_pc || if_ir !== hold_ir) begin
                        bad++;
                        $display("FAIL hold: valid=%b pc=%h ir=%h, need valid=1 pc=%h ir=%h", if_valid, if_pc, if_ir, hold_pc, hold_ir);
                    end
                end
                if (!if_valid) begin
                    total++;
                    if (if_ir !== NOP || if_pc !== '0) begin
                        bad++;
                        $display("FAIL empty_out: ir=%h pc=%h, need ir=%h pc=0", if_ir, if_pc, NOP);
                    end
                end
                if (if_valid && if_ready) begin
                    total++;
                    if (if_pc !== exp_deliv || if_ir !== 32'(exp_deliv)) begin
                        bad++;
                        $display("FAIL deliver: pc=%h ir=%h, need pc=%h ir=%h", if_pc, if_ir, exp_deliv, 32'(exp_deliv));
                    end
                    exp_deliv = exp_deliv + pc_t'(4);
                    outstanding--;
                    d_count++;
                end
                if (imem_en) begin
                    total++;
                    if (redirect || imem_addr !== exp_issue) begin
                        bad++;
                        $display("FAIL issue: addr=%h redirect=%b, need addr=%h redirect=0", imem_addr, redirect, exp_issue);
                    end
                    exp_issue = exp_issue + pc_t'(4);
                    outstanding++;
                end
                if (redirect) begin
                    exp_issue = redirect_pc & ~pc_t'(3);
                    exp_deliv = redirect_pc & ~pc_t'(3);
                    outstanding = 0;
                end
                total++;
                if (outstanding > DEPTH || outstanding < 0) begin
                    bad++;
                    $display("FAIL credit: outstanding=%0d, need 0..%0d", outstanding, DEPTH);
                end
                hold_q = if_valid && !if_ready && !redirect;
                hold_pc = if_pc;
                hold_ir = if_ir;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, need finish");
        $fatal(1, "watchdog");
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic rdy);
        next_cycle();
        reset = 1'b1;
        redirect = 1'b0;
        if_ready = rdy;
        next_cycle();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        if_ready = 1'b1;
        next_cycle();
        mon_on = 1'b1;
        next_cycle();
        @(negedge clk);
        total++;
        if (if_valid !== 1'b0 || if_ir !== NOP || if_pc !== '0 || imem_en !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: valid=%b ir=%h pc=%h en=%b, need 0 %h 0 0", if_valid, if_ir, if_pc, imem_en, NOP);
        end
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        total++;
        if (imem_en !== 1'b1 || imem_addr !== pc_t'(INIT_PC) || if_valid !== 1'b0) begin
            bad++;
            $display("FAIL first_fetch: en=%b addr=%h valid=%b, need 1 %h 0", imem_en, imem_addr, if_valid, pc_t'(INIT_PC));
        end
        next_cycle();
        @(negedge clk);
        total++;
        if (if_valid !== 1'b0) begin
            bad++;
            $display("FAIL cycle1_valid: valid=%b, need 0", if_valid);
        end
        next_cycle();
        @(negedge clk);
        total++;
        if (if_valid !== 1'b1 || if_pc !== 9'h000) begin
            bad++;
            $display("FAIL cycle2_valid: valid=%b pc=%h, need 1 000", if_valid, if_pc);
        end
    endtask

    task automatic test_stream();
        int start = d_count;
        for (int i = 0; i < 10; i++) begin
            next_cycle();
            @(negedge clk);
            total++;
            if (if_valid !== 1'b1 || if_pc !== pc_t'(4 * (i + 1))) begin
                bad++;
                $display("FAIL stream[%0d]: valid=%b pc=%h, need 1 %h", i, if_valid, if_pc, pc_t'(4 * (i + 1)));
            end
        end
        next_cycle();
        total++;
        if (d_count - start !== 11) begin
            bad++;
            $display("FAIL stream_rate: delivered=%0d, need 11", d_count - start);
        end
    endtask

    task automatic test_stall();
        do_reset(1'b0);
        next_cycle();
        next_cycle();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if (if_valid !== 1'b1 || if_pc !== 9'h000) begin
                bad++;
                $display("FAIL stall_hold[%0d]: valid=%b pc=%h, need 1 000", i, if_valid, if_pc);
            end
            if (i == 4) begin
                total++;
                if (imem_en !== 1'b0) begin
                    bad++;
                    $display("FAIL stall_en: en=%b, need 0", imem_en);
                end
            end
            next_cycle();
        end
        if_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            total++;
            if (if_valid !== 1'b1) begin
                bad++;
                $display("FAIL resume[%0d]: valid=%b, need 1", i, if_valid);
            end
            next_cycle();
        end
        @(negedge clk);
        total++;
        if (if_pc !== 9'h028) begin
            bad++;
            $display("FAIL resume_pc: pc=%h, need 028", if_pc);
        end
    endtask

    task automatic test_redirect_full();
        bit got = 1'b0;
        do_reset(1'b0);
        for (int i = 0; i < 5; i++) next_cycle();
        redirect = 1'b1;
        redirect_pc = 9'h043;
        @(negedge clk);
        total++;
        if (imem_en !== 1'b0 || if_valid !== 1'b1) begin
            bad++;
            $display("FAIL redir_cycle: en=%b valid=%b, need 0 1", imem_en, if_valid);
        end
        next_cycle();
        redirect = 1'b0;
        @(negedge clk);
        total++;
        if (if_valid !== 1'b0 || if_ir !== NOP || imem_addr !== 9'h040 || imem_en !== 1'b1) begin
            bad++;
            $display("FAIL redir_flush: valid=%b ir=%h addr=%h en=%b, need 0 %h 040 1", if_valid, if_ir, imem_addr, imem_en, NOP);
        end
        next_cycle();
        if_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (if_valid) begin
                got = 1'b1;
                break;
            end
            next_cycle();
        end
        total++;
        if (!got || if_pc !== 9'h040) begin
            bad++;
            $display("FAIL redir_target: got=%b pc=%h, need 1 040", got, if_pc);
        end
    endtask

    task automatic test_redirect_inflight();
        pc_t tgt = pc_t'($urandom);
        do_reset(1'b1);
        for (int i = 0; i < 6; i++) next_cycle();
        @(negedge clk);
        total++;
        if (imem_en !== 1'b1) begin
            bad++;
            $display("FAIL inflight_pre: en=%b, need 1", imem_en);
        end
        next_cycle();
        redirect = 1'b1;
        redirect_pc = tgt;
        next_cycle();
        redirect = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            total++;
            if (if_valid !== 1'b0) begin
                bad++;
                $display("FAIL kill[%0d]: valid=%b pc=%h, need valid=0", i, if_valid, if_pc);
            end
            next_cycle();
        end
        @(negedge clk);
        total++;
        if (if_valid !== 1'b1 || if_pc !== (tgt & ~pc_t'(3))) begin
            bad++;
            $display("FAIL kill_target: valid=%b pc=%h, need 1 %h", if_valid, if_pc, tgt & ~pc_t'(3));
        end
    endtask

    task automatic test_wrap();
        bit found = 1'b0;
        do_reset(1'b1);
        next_cycle();
        redirect = 1'b1;
        redirect_pc = 9'h1F0;
        next_cycle();
        redirect = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (imem_en && imem_addr === 9'h1FC) begin
                found = 1'b1;
                break;
            end
        end
        @(negedge clk);
        total++;
        if (!found || imem_en !== 1'b1 || imem_addr !== 9'h000) begin
            bad++;
            $display("FAIL wrap: found=%b en=%b addr=%h, need 1 1 000", found, imem_en, imem_addr);
        end
        for (int i = 0; i < 8; i++) next_cycle();
    endtask

    task automatic test_reset_mid();
        do_reset(1'b0);
        for (int i = 0; i < 5; i++) next_cycle();
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        total++;
        if (if_valid !== 1'b0 || if_ir !== NOP || imem_addr !== pc_t'(INIT_PC) || imem_en !== 1'b1) begin
            bad++;
            $display("FAIL reset_full: valid=%b ir=%h addr=%h en=%b, need 0 %h %h 1", if_valid, if_ir, imem_addr, imem_en, NOP, pc_t'(INIT_PC));
        end
        do_reset(1'b0);
        next_cycle();
        next_cycle();
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        if_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            total++;
            if (if_valid !== 1'b0) begin
                bad++;
                $display("FAIL late_resp[%0d]: valid=%b pc=%h, need valid=0", i, if_valid, if_pc);
            end
            next_cycle();
        end
        @(negedge clk);
        total++;
        if (if_valid !== 1'b1 || if_pc !== pc_t'(INIT_PC)) begin
            bad++;
            $display("FAIL reset_restart: valid=%b pc=%h, need 1 %h", if_valid, if_pc, pc_t'(INIT_PC));
        end
    endtask

    task automatic test_random();
        int start;
        do_reset(1'b1);
        start = d_count;
        for (int i = 0; i < 400; i++) begin
            next_cycle();
            if_ready = ($urandom_range(3) != 0);
            redirect = ($urandom_range(15) == 0);
            redirect_pc = pc_t'($urandom);
            reset = ($urandom_range(79) == 0);
        end
        next_cycle();
        reset = 1'b0;
        redirect = 1'b0;
        if_ready = 1'b1;
        for (int i = 0; i < 6; i++) next_cycle();
        total++;
        if (d_count - start < 100) begin
            bad++;
            $display("FAIL random_liveness: delivered=%0d, need >=100", d_count - start);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect_full();
        test_redirect_inflight();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter: DEPTH, 2, instruction queue entries (power of two, >=2).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: imem_en  output  1  instruction memory read strobe.
REQ-005 SHALL have port: imem_addr  output  pc_t  byte address of the read.
REQ-006 SHALL have port: imem_data  input  32  read data, valid exactly one cycle after imem_en.
REQ-007 SHALL have port: redirect  input  1  branch/jump taken; replaces the PC and flushes.
REQ-008 SHALL have port: redirect_pc  input  pc_t  redirect target.
REQ-009 SHALL have port: if_valid  output  1  instruction available to decode.
REQ-010 SHALL have port: if_ready  input  1  decode accepts this cycle.
REQ-011 SHALL have port: if_ir  output  ir_t  fetched instruction.
REQ-012 SHALL have port: if_pc  output  pc_t  address of if_ir.

Function
REQ-013 SHALL hold fetch PC register; imem_addr = PC combinationally.
REQ-014 SHALL assert imem_en only when queue occupancy + in-flight reads < DEPTH and redirect is low; PC += 4 on each such cycle, wrapping modulo 2^width(pc_t).
REQ-015 SHALL write {imem_data, issued PC} into the queue the cycle after imem_en, unless that read was killed.
REQ-016 SHALL transfer an instruction only when if_valid && if_ready, popping the queue head.
REQ-017 SHALL drive if_valid = queue not empty; if_ir/if_pc from queue head; if_ir = NOP when empty.
REQ-018 SHALL sustain one instruction per cycle with if_ready held high; first valid 2 cycles after reset release.
REQ-019 SHALL on redirect: PC <= redirect_pc with bits [1:0] forced to 0, queue emptied, any in-flight read killed, no imem_en that cycle; next read at the target the following cycle.
REQ-020 SHALL treat redirect concurrent with a handshake as redirect winning; the accepted instruction counts as delivered and is not replayed.
REQ-021 SHALL support simultaneous push and pop when full (occupancy unchanged) and when empty (no bypass; the entry appears next cycle).
REQ-022 SHALL keep queue pointers DEPTH-modulo with explicit occupancy count; never overflow (guaranteed by REQ-014).
REQ-023 SHALL hold if_ir/if_pc stable while if_valid && !if_ready.

Reset
REQ-024 SHALL on reset: PC = riscv::INIT_PC (truncated to pc_t), queue empty, in-flight cleared, imem_en = 0, if_valid = 0, if_ir = NOP, if_pc = 0.
REQ-025 SHALL have reset take priority over redirect and discard any response arriving the cycle after reset.

Structure
REQ-026 SHALL import ir_t, pc_t, NOP, INIT_PC from package riscv; no local redefinition.
REQ-027 SHALL add to package riscv a packed struct fetch_entry_t {ir_t ir; pc_t pc;}.
REQ-028 SHALL implement the queue as sub-module fetch_queue (synchronous FIFO, DEPTH parameter, push/pop/flush, count).
REQ-029 SHALL use a single kill flag registered alongside the in-flight bit for response cancellation.

Verification
REQ-030 SHALL cover reset release, if_ready=1, memory returns word = address: if_pc sequence 0x000,0x004,0x008 from cycle 2, one per cycle.
REQ-031 SHALL cover if_ready=0 for 5 cycles after first valid: imem_en deasserts once count+inflight=2; if_pc holds 0x000; resumes with no lost or duplicated PC.
REQ-032 SHALL cover redirect=1, redirect_pc=0x043 while queue full: next cycle if_valid=0, if_ir=NOP; imem_addr=0x040; first delivered if_pc=0x040.
REQ-033 SHALL cover redirect in the cycle after imem_en: killed response never appears at if_pc.
REQ-034 SHALL cover PC at 0x1FC: next issued address 0x000 (wrap).
REQ-035 SHALL cover reset asserted mid-stream with queue full: next cycle if_valid=0, PC=INIT_PC value, late response discarded.
